// File: rtl/axi_rb_pkg.sv
// Shared types and helpers for the AXI4 read-burst engine.
// The optional 4 KiB split is controlled by the macro AXI_RB_4K_SPLIT_EN (see axi_rb_burst_calc).
package axi_rb_pkg;

    typedef enum logic [1:0] {IDLE, AR, R, FLUSH} rb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         AXI_4K         = 4096;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic logic [2:0] arsize_for(input int data_w);
        return 3'(clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_burst_reader_if.sv
// Job, AXI4 read (AR/R) and output-stream signals of the burst reader.
// master = the engine, slave = the environment (memory port, job source, sink).
interface axi_burst_reader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              cfg_valid, cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [LEN_W-1:0]  cfg_len;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid, arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid, rlast, rready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_ready;
    logic              busy, done;

    modport master (
        input  cfg_valid, cfg_addr, cfg_len, arready, rdata, rvalid, rlast, out_ready,
        output cfg_ready, araddr, arlen, arsize, arburst, arvalid, rready,
               out_data, out_valid, busy, done
    );

    modport slave (
        output cfg_valid, cfg_addr, cfg_len, arready, rdata, rvalid, rlast, out_ready,
        input  cfg_ready, araddr, arlen, arsize, arburst, arvalid, rready,
               out_data, out_valid, busy, done
    );

endinterface

// File: rtl/axi_rb_burst_calc.sv
// Combinational burst-length selection: min(rem, MAX_BURST), optionally capped at the next 4 KiB
// boundary when AXI_RB_4K_SPLIT_EN is defined (requires ADDR_W >= 12).
module axi_rb_burst_calc
    import axi_rb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic [LEN_W-1:0]  rem,
    input  logic [ADDR_W-1:0] cur_addr,
    output logic [8:0]        blen
);
    localparam int SHIFT = clog2(DATA_W / 8);

    logic unused_addr;
    assign unused_addr = ^cur_addr;

`ifdef AXI_RB_4K_SPLIT_EN
    logic [12:0] to_4k;
    assign to_4k = (13'(AXI_4K) - {1'b0, cur_addr[11:0]}) >> SHIFT;

    always_comb begin
        blen = (32'(rem) >= MAX_BURST) ? 9'(MAX_BURST) : 9'(rem);
        if (to_4k < {4'b0, blen}) blen = to_4k[8:0];
    end
`else
    always_comb begin
        blen = (32'(rem) >= MAX_BURST) ? 9'(MAX_BURST) : 9'(rem);
    end
`endif

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read-burst engine: splits an (addr, beats) job into INCR bursts and streams beats through a
// one-entry output buffer. Optional 4 KiB burst splitting via AXI_RB_4K_SPLIT_EN.
module axi_burst_reader
    import axi_rb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    axi_burst_reader_if.master  bus
);
    localparam int BYTES = DATA_W / 8;

    rb_state_t         state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  rem;
    logic [8:0]        blen, blen_r, beat_cnt;
    logic              beat;
    logic              unused_rlast;

    axi_rb_burst_calc #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
    ) u_calc (
        .rem(rem), .cur_addr(cur_addr), .blen(blen)
    );

    // rlast is not trusted; the beat counter decides where a burst ends.
    assign unused_rlast = bus.rlast;
    assign bus.arsize   = arsize_for(DATA_W);
    assign bus.arburst  = AXI_BURST_INCR;
    assign bus.rready   = (state == R) && (!bus.out_valid || bus.out_ready);
    assign beat         = bus.rvalid && bus.rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.cfg_ready <= 1'b1;
            bus.arvalid   <= 1'b0;
            bus.araddr    <= '0;
            bus.arlen     <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            cur_addr      <= '0;
            rem           <= '0;
            blen_r        <= '0;
            beat_cnt      <= '0;
        end else begin
            bus.done <= 1'b0;

            // A push in the same cycle as a pop keeps the buffer full.
            if (beat) begin
                bus.out_data  <= bus.rdata;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            case (state)
                IDLE: if (bus.cfg_valid) begin
                    cur_addr <= bus.cfg_addr;
                    rem      <= bus.cfg_len;
                    if (bus.cfg_len == '0) begin
                        bus.done <= 1'b1;
                    end else begin
                        state         <= AR;
                        bus.busy      <= 1'b1;
                        bus.cfg_ready <= 1'b0;
                    end
                end
                AR: if (!bus.arvalid) begin
                    bus.araddr  <= cur_addr;
                    bus.arlen   <= 8'(blen - 9'd1);
                    blen_r      <= blen;
                    bus.arvalid <= 1'b1;
                end else if (bus.arready) begin
                    bus.arvalid <= 1'b0;
                    beat_cnt    <= blen_r;
                    state       <= R;
                end
                R: if (beat) begin
                    beat_cnt <= beat_cnt - 9'd1;
                    rem      <= rem - LEN_W'(1);
                    if (beat_cnt == 9'd1) begin
                        cur_addr <= cur_addr + ADDR_W'(32'(blen_r) * BYTES);
                        state    <= (rem == LEN_W'(1)) ? FLUSH : AR;
                    end
                end
                FLUSH: if (!bus.out_valid || bus.out_ready) begin
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.cfg_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench for axi_burst_reader: directed table, mid-burst reset and random jobs against a burst/data model.
// Expectations follow AXI_RB_4K_SPLIT_EN when the bundle is built with it.
module tb_axi_burst_reader;
    localparam int AW = 16, DW = 32, LW = 16, MAXB = 16;

    logic clk, rst;
    axi_burst_reader_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    axi_burst_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // Environment knobs set by the test sequence.
    int ar_delay = 0, out_mode = 0, rv_mode = 0;

    // ---------------- AXI slave memory ----------------
    typedef struct { logic [15:0] addr; int len; } burst_t;
    burst_t pend[$];
    int bidx = 0, ar_wait = 0;
    logic s_rst, s_ar, s_r;
    logic [15:0] s_araddr;
    logic [7:0]  s_arlen;

    initial begin
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rlast = 0;
        forever begin
            @(negedge clk);
            s_rst = rst; s_ar = bus.arvalid && bus.arready; s_r = bus.rvalid && bus.rready;
            s_araddr = bus.araddr; s_arlen = bus.arlen;
            if (bus.arvalid && !bus.arready) ar_wait++;
            @(posedge clk); #1;
            if (s_rst) begin
                pend.delete(); bidx = 0; ar_wait = 0;
                bus.arready = 0; bus.rvalid = 0; bus.rlast = 0;
            end else begin
                if (s_ar) begin
                    pend.push_back('{s_araddr, int'(s_arlen) + 1});
                    ar_wait = 0;
                end
                if (s_r) begin
                    bidx++;
                    if (bidx == pend[0].len) begin
                        void'(pend.pop_front());
                        bidx = 0;
                    end
                end
                bus.arready = bus.arvalid && (ar_wait >= ar_delay);
                if (pend.size() == 0) bus.rvalid = 0;
                else if (!(bus.rvalid && !s_r)) bus.rvalid = (rv_mode == 0) || ($urandom_range(0, 3) != 0);
                if (pend.size() != 0) begin
                    bus.rdata = memw(pend[0].addr + 16'(bidx * 4));
                    bus.rlast = (bidx == pend[0].len - 1);
                end
            end
        end
    end

    // ---------------- output sink ----------------
    initial begin
        bus.out_ready = 0;
        forever begin
            @(posedge clk); #1;
            case (out_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = !bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    logic [23:0] obs_ar[$];
    logic [31:0] got[$];
    int cyc = 0, done_cnt = 0, done_cyc = -1, accept_cyc = -1, last_hs_cyc = -1, arv_cycles = 0;
    logic done_cfg_ready, done_busy;
    logic p_ar_stall = 0, p_out_stall = 0;
    logic [15:0] p_araddr;
    logic [7:0]  p_arlen;
    logic [31:0] p_out_data;

    always @(negedge clk) begin
        cyc++;
        if (p_ar_stall) begin
            chk("ar_hold_valid", bus.arvalid, 1);
            chk("ar_hold_addr", bus.araddr, p_araddr);
            chk("ar_hold_len", bus.arlen, p_arlen);
        end
        if (p_out_stall) begin
            chk("out_hold_valid", bus.out_valid, 1);
            chk("out_hold_data", bus.out_data, p_out_data);
        end
        if (bus.out_valid && !bus.out_ready) chk("rready_when_full", bus.rready, 0);
        p_ar_stall  = !rst && bus.arvalid && !bus.arready;
        p_out_stall = !rst && bus.out_valid && !bus.out_ready;
        p_araddr = bus.araddr; p_arlen = bus.arlen; p_out_data = bus.out_data;
        if (!rst) begin
            if (bus.arvalid && bus.arready) begin
                obs_ar.push_back({bus.araddr, bus.arlen});
                chk("arsize", bus.arsize, 3'd2);
                chk("arburst", bus.arburst, 2'b01);
            end
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                last_hs_cyc = cyc;
            end
            if (bus.cfg_valid && bus.cfg_ready) accept_cyc = cyc;
        end
        if (bus.arvalid) arv_cycles++;
        if (bus.done) begin
            if (done_cnt == 0) begin
                done_cyc = cyc; done_cfg_ready = bus.cfg_ready; done_busy = bus.busy;
            end
            done_cnt++;
        end
    end

    // ---------------- reference model ----------------
    logic [23:0] exp_ar[$];
    logic [31:0] exp_data[$];

    function automatic void build_model(input logic [15:0] a, input int len);
        int rem, b;
        logic [15:0] cur;
        rem = len; cur = a;
        exp_ar.delete(); exp_data.delete();
        for (int i = 0; i < len; i++) exp_data.push_back(memw(a + 16'(4 * i)));
        while (rem > 0) begin
            b = (rem < MAXB) ? rem : MAXB;
`ifdef AXI_RB_4K_SPLIT_EN
            if ((4096 - int'(cur[11:0])) / 4 < b) b = (4096 - int'(cur[11:0])) / 4;
`endif
            exp_ar.push_back({cur, 8'(b - 1)});
            cur = cur + 16'(b * 4);
            rem -= b;
        end
    endfunction

    task automatic start_job(input logic [15:0] a, input int len);
        int n;
        n = 0;
        @(posedge clk); #1;
        obs_ar.delete(); got.delete();
        done_cnt = 0; arv_cycles = 0; accept_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        bus.cfg_valid = 1; bus.cfg_addr = a; bus.cfg_len = 16'(len);
        do begin @(negedge clk); n++; end while (!bus.cfg_ready && n < 100);
        chk("cfg_accept", bus.cfg_ready, 1);
        @(posedge clk); #1;
        bus.cfg_valid = 0;
    endtask

    task automatic finish_job();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_job(input string tag, input logic [15:0] a, input int len);
        int exp_done;
        build_model(a, len);
        chk({tag, "_n_ar"}, obs_ar.size(), exp_ar.size());
        for (int i = 0; i < obs_ar.size() && i < exp_ar.size(); i++)
            chk($sformatf("%s_ar%0d", tag, i), obs_ar[i], exp_ar[i]);
        chk({tag, "_n_beats"}, got.size(), exp_data.size());
        for (int i = 0; i < got.size() && i < exp_data.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), got[i], exp_data[i]);
        chk({tag, "_done_count"}, done_cnt, 1);
        exp_done = (len == 0) ? accept_cyc + 1 : last_hs_cyc + 1;
        chk({tag, "_done_time"}, done_cyc, exp_done);
        chk({tag, "_cfg_ready_at_done"}, done_cfg_ready, 1);
        chk({tag, "_busy_at_done"}, done_busy, 0);
        if (len == 0) chk({tag, "_no_arvalid"}, arv_cycles, 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [15:0] addr; int len; int ar_delay; int omode; int rmode;
        int n_ar; logic [15:0] ar0_addr; int ar0_len; int arl_len;
    } vec_t;
    vec_t vec[7];

    initial begin
        vec[0] = '{16'h0100,  8, 0, 0, 0, 1, 16'h0100,  7,  7};
        vec[1] = '{16'h0100, 40, 0, 0, 0, 3, 16'h0100, 15,  7};
        vec[2] = '{16'h0040,  0, 0, 0, 0, 0, 16'h0000,  0,  0};
        vec[3] = '{16'h0200, 16, 3, 1, 0, 1, 16'h0200, 15, 15};
`ifdef AXI_RB_4K_SPLIT_EN
        vec[4] = '{16'h0FF0,  8, 0, 0, 0, 2, 16'h0FF0,  3,  3};
`else
        vec[4] = '{16'h0FF0,  8, 0, 0, 0, 1, 16'h0FF0,  7,  7};
`endif
        vec[5] = '{16'hFFC0, 32, 1, 2, 1, 2, 16'hFFC0, 15, 15};
        vec[6] = '{16'h2000, 17, 2, 2, 1, 2, 16'h2000, 15,  0};

        rst = 1; bus.cfg_valid = 0; bus.cfg_addr = 0; bus.cfg_len = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_araddr", bus.araddr, 0);
        chk("rst_arlen", bus.arlen, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_arsize", bus.arsize, 3'd2);
        chk("rst_arburst", bus.arburst, 2'b01);
        @(posedge clk); #1;
        rst = 0;

        for (int r = 0; r < 7; r++) begin
            ar_delay = vec[r].ar_delay; out_mode = vec[r].omode; rv_mode = vec[r].rmode;
            start_job(vec[r].addr, vec[r].len);
            finish_job();
            chk($sformatf("row%0d_tbl_n_ar", r), obs_ar.size(), vec[r].n_ar);
            if (vec[r].n_ar > 0 && obs_ar.size() > 0) begin
                chk($sformatf("row%0d_tbl_ar0_addr", r), obs_ar[0][23:8], vec[r].ar0_addr);
                chk($sformatf("row%0d_tbl_ar0_len", r), obs_ar[0][7:0], vec[r].ar0_len);
                chk($sformatf("row%0d_tbl_arl_len", r), obs_ar[obs_ar.size() - 1][7:0], vec[r].arl_len);
            end
            check_job($sformatf("row%0d", r), vec[r].addr, vec[r].len);
        end

        // Reset in the middle of a 16-beat burst, after 5 beats have left the engine.
        ar_delay = 0; out_mode = 0; rv_mode = 0;
        start_job(16'h0300, 16);
        for (int n = 0; n < 500 && got.size() < 5; n++) @(negedge clk);
        chk("midrst_reached_beat5", got.size() >= 5, 1);
        @(posedge clk); #1;
        rst = 1; done_cnt = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_cfg_ready", bus.cfg_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_arvalid", bus.arvalid, 0);
        repeat (10) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        start_job(16'h0400, 20);
        finish_job();
        check_job("after_rst", 16'h0400, 20);

        // Random jobs against the model.
        for (int j = 0; j < 25; j++) begin
            logic [15:0] a;
            int len;
            a = 16'($urandom_range(0, 16383) * 4);
            len = $urandom_range(0, 48);
            ar_delay = $urandom_range(0, 3); out_mode = $urandom_range(0, 2); rv_mode = $urandom_range(0, 1);
            start_job(a, len);
            finish_job();
            check_job($sformatf("rnd%0d", j), a, len);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
